// File: rtl/dispatch_router.sv
// 1-to-N op distributor: routes each accepted op into a per-destination FIFO (one cycle, no fall-through).
// in_reject is driven only by reset/flash/full, never by out_reject; out_msg reads the FIFO head asynchronously.
module dispatch_router #(
  parameter int NUM_RS = 7,
  parameter int MSG_W  = 49,
  parameter int DEPTH  = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flash,
  input  logic                                    in_en,
  input  logic [MSG_W-1:0]                        in_msg,
  input  logic [$clog2(NUM_RS)-1:0]               in_dest,
  output logic                                    in_reject,
  output logic [NUM_RS-1:0]                       out_en,
  output logic [NUM_RS*MSG_W-1:0]                 out_msg,
  input  logic [NUM_RS-1:0]                       out_reject,
  output logic [NUM_RS*($clog2(DEPTH)+1)-1:0]     occupancy,
  output logic                                    bad_dest
);

  localparam int DW = $clog2(NUM_RS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [MSG_W-1:0] mem_q [NUM_RS][DEPTH];
  logic [PW-1:0]    head_q  [NUM_RS];
  logic [PW-1:0]    head_d  [NUM_RS];
  logic [PW-1:0]    tail_q  [NUM_RS];
  logic [PW-1:0]    tail_d  [NUM_RS];
  logic [CW-1:0]    count_q [NUM_RS];
  logic [CW-1:0]    count_d [NUM_RS];
  logic             bad_q, bad_d;

  logic              dest_ok, accept;
  logic [NUM_RS-1:0] sel, full, push, pop;

  always_comb begin
    dest_ok   = (int'(in_dest) < NUM_RS);
    sel       = '0;
    full      = '0;
    out_en    = '0;
    out_msg   = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      sel[i]  = dest_ok && (in_dest == DW'(i));
      full[i] = (count_q[i] == CW'(DEPTH));
      out_en[i] = ~reset & ~flash & (count_q[i] != '0);
      out_msg[i*MSG_W +: MSG_W] = mem_q[i][head_q[i]];
      occupancy[i*CW +: CW]     = count_q[i];
    end

    // Full rejects even when the same FIFO pops this cycle, keeping out_reject off this path.
    in_reject = reset | flash | (|(sel & full));
    accept    = in_en & ~in_reject;
    push      = accept ? sel : '0;
    pop       = out_en & ~out_reject;
    bad_d     = bad_q | (accept & ~dest_ok);

    for (int i = 0; i < NUM_RS; i++) begin
      head_d[i]  = head_q[i] + PW'(pop[i]);
      tail_d[i]  = tail_q[i] + PW'(push[i]);
      count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (flash) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      bad_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      bad_q <= bad_d;
    end
  end

  // Storage needs no reset: push is forced low during reset and flash.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_RS; i++) begin
      if (push[i]) mem_q[i][tail_q[i]] <= in_msg;
    end
  end

  assign bad_dest = bad_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: vector table, directed corner sequences, random traffic vs a queue model.
module tb_dispatch_router;
  localparam int N  = 7;
  localparam int W  = 49;
  localparam int D  = 4;
  localparam int DW = 3;
  localparam int CW = 3;

  logic            clock = 1'b0;
  logic            reset, flash, in_en;
  logic [W-1:0]    in_msg;
  logic [DW-1:0]   in_dest;
  logic            in_reject;
  logic [N-1:0]    out_en, out_reject;
  logic [N*W-1:0]  out_msg;
  logic [N*CW-1:0] occupancy;
  logic            bad_dest;

  dispatch_router #(.NUM_RS(N), .MSG_W(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .flash(flash), .in_en(in_en), .in_msg(in_msg),
    .in_dest(in_dest), .in_reject(in_reject), .out_en(out_en), .out_msg(out_msg),
    .out_reject(out_reject), .occupancy(occupancy), .bad_dest(bad_dest)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per destination plus a sticky flag.
  logic [W-1:0] mq [N][$];
  logic         mbad;
  logic         exp_rej;
  logic [N-1:0] exp_en;

  task automatic drive(input logic r, input logic f, input logic e, input logic [DW-1:0] d,
                       input logic [W-1:0] m, input logic [N-1:0] o);
    reset = r; flash = f; in_en = e; in_dest = d; in_msg = m; out_reject = o;
  endtask

  task automatic model_check();
    int dd;
    dd = int'(in_dest);
    exp_rej = reset | flash | ((dd < N) && (mq[dd].size() == D));
    for (int i = 0; i < N; i++) exp_en[i] = !reset && !flash && (mq[i].size() != 0);
    check("in_reject", 64'(in_reject), 64'(exp_rej));
    check("out_en", 64'(out_en), 64'(exp_en));
    check("bad_dest", 64'(bad_dest), 64'(mbad));
    for (int i = 0; i < N; i++) begin
      check($sformatf("occupancy[%0d]", i), 64'(occupancy[i*CW +: CW]), 64'(mq[i].size()));
      if (mq[i].size() != 0)
        check($sformatf("out_msg[%0d]", i), 64'(out_msg[i*W +: W]), 64'(mq[i][0]));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mbad = 1'b0;
    end else if (flash) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < N; i++)
        if (exp_en[i] && !out_reject[i]) void'(mq[i].pop_front());
      if (in_en && !exp_rej) begin
        if (int'(in_dest) < N) mq[int'(in_dest)].push_back(in_msg);
        else mbad = 1'b1;
      end
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic cycle(input logic r, input logic f, input logic e, input logic [DW-1:0] d,
                       input logic [W-1:0] m, input logic [N-1:0] o, output logic acc);
    drive(r, f, e, d, m, o);
    #3;
    model_check();
    acc = e && !exp_rej;
    @(posedge clock);
    model_update();
    #1;
  endtask

  typedef struct {
    logic            rst, fl, en;
    logic [DW-1:0]   dest;
    logic [W-1:0]    msg;
    logic [N-1:0]    orej;
    logic            exp_rej;
    logic [N-1:0]    exp_en;
    logic [N*CW-1:0] exp_occ;
    logic            exp_bad;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic          acc;
    logic [63:0]   r64;
    int            tries;
    logic [W-1:0]  held;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 3'd2, 49'h1_2345_6789, 7'h00, 1'b0, 7'h00, 21'h0,  1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 49'h0,           7'h00, 1'b0, 7'h04, 21'h40, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 49'h0,           7'h00, 1'b0, 7'h00, 21'h0,  1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 3'd7, 49'h5A5A,        7'h00, 1'b0, 7'h00, 21'h0,  1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 49'h0,           7'h00, 1'b0, 7'h00, 21'h0,  1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 3'd1, 49'h77,          7'h00, 1'b1, 7'h00, 21'h0,  1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 49'h0,           7'h00, 1'b0, 7'h00, 21'h0,  1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 3'd0, 49'h0,           7'h00, 1'b1, 7'h00, 21'h0,  1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 3'd0, 49'h0,           7'h00, 1'b0, 7'h00, 21'h0,  1'b0};

    for (int i = 0; i < N; i++) mq[i].delete();
    mbad = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    #3;
    check("reset in_reject", 64'(in_reject), 64'd1);
    check("reset out_en", 64'(out_en), 64'd0);
    repeat (2) @(posedge clock);
    #1;

    // Vector table: single op to dest 2, bad dest, flash holding bad_dest, reset clearing it.
    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].rst, tbl[v].fl, tbl[v].en, tbl[v].dest, tbl[v].msg, tbl[v].orej);
      #3;
      check($sformatf("vec%0d in_reject", v), 64'(in_reject), 64'(tbl[v].exp_rej));
      check($sformatf("vec%0d out_en", v), 64'(out_en), 64'(tbl[v].exp_en));
      check($sformatf("vec%0d occupancy", v), 64'(occupancy), 64'(tbl[v].exp_occ));
      check($sformatf("vec%0d bad_dest", v), 64'(bad_dest), 64'(tbl[v].exp_bad));
      if (tbl[v].exp_en[2])
        check($sformatf("vec%0d out_msg[2]", v), 64'(out_msg[2*W +: W]), 64'h1_2345_6789);
      model_check();
      @(posedge clock);
      model_update();
      #1;
    end

    // Dest 5 held full, fifth op held until a slot frees.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 3'd5, W'(k), 7'h20, acc);
    held = W'(4);
    cycle(1'b0, 1'b0, 1'b1, 3'd5, held, 7'h20, acc);
    check("full dest5 occupancy", 64'(occupancy[5*CW +: CW]), 64'd4);
    check("full dest5 held op rejected", 64'(acc), 64'd0);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 10) begin
      cycle(1'b0, 1'b0, 1'b1, 3'd5, held, 7'h00, acc);
      tries++;
    end
    check("held op accepted after release", 64'(acc), 64'd1);
    check("held op needed two tries", 64'(tries), 64'd2);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 3'd0, '0, 7'h00, acc);

    // Dest 3: full with pop+push rejects; count 2 with pop+push stays 2.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 3'd3, W'(16 + k), 7'h08, acc);
    cycle(1'b0, 1'b0, 1'b1, 3'd3, W'(20), 7'h00, acc);
    check("full pop+push rejected", 64'(acc), 64'd0);
    check("full pop+push occupancy", 64'(occupancy[3*CW +: CW]), 64'd3);
    cycle(1'b0, 1'b0, 1'b0, 3'd3, '0, 7'h00, acc);
    cycle(1'b0, 1'b0, 1'b1, 3'd3, W'(21), 7'h00, acc);
    check("count2 pop+push accepted", 64'(acc), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 3'd3, '0, 7'h08, acc);
    check("count2 pop+push occupancy", 64'(occupancy[3*CW +: CW]), 64'd2);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 3'd0, '0, 7'h00, acc);

    // Ten ops alternating dests 0/6 while draining, wrapping the pointers.
    for (int k = 0; k < 10; k++)
      cycle(1'b0, 1'b0, 1'b1, (k % 2 == 0) ? 3'd0 : 3'd6, W'(49'h100 + k), 7'h00, acc);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 3'd0, '0, 7'h00, acc);

    // Flash with full-ish FIFOs and a push attempt.
    for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b1, 3'd1, W'(49'h200 + k), 7'h7F, acc);
    for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b1, 3'd4, W'(49'h300 + k), 7'h7F, acc);
    cycle(1'b0, 1'b1, 1'b1, 3'd1, W'(49'h3FF), 7'h00, acc);
    check("flash push rejected", 64'(acc), 64'd0);
    #3;
    check("after flash occupancy", 64'(occupancy), 64'd0);
    check("after flash out_en", 64'(out_en), 64'd0);
    #1;
    @(posedge clock);
    #1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r64 = {$urandom(), $urandom()};
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), DW'($urandom_range(0, 7)), r64[W-1:0],
            N'($urandom() & $urandom()), acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
